// File: rtl/debounce_timer_scheduler.sv
// N-channel push-button debouncer sharing one qualification timer.
// Channels with a pending change are granted the timer round-robin.
module debounce_timer_scheduler #(
   parameter int N          = 4,
   parameter int CH_BITS    = 2,
   parameter int TICKS      = 1000000,
   parameter int TIMER_BITS = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       noisy,
   output logic [N-1:0]       debounced,
   output logic [N-1:0]       press_pulse,
   output logic [N-1:0]       release_pulse,
   output logic               busy,
   output logic [CH_BITS-1:0] active_ch
);

   typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

   state_t                state_q, state_d;
   logic [N-1:0]          meta_q, sync_q;
   logic [N-1:0]          deb_q, deb_d;
   logic [N-1:0]          press_q, press_d;
   logic [N-1:0]          rel_q, rel_d;
   logic [CH_BITS-1:0]    ch_q, ch_d;
   logic [CH_BITS-1:0]    rr_q, rr_d;
   logic [TIMER_BITS-1:0] timer_q, timer_d;

   logic [N-1:0]          pend;
   logic                  found;
   logic [CH_BITS-1:0]    grant;

   // A channel wants the timer whenever its synchronised level disagrees with its accepted level.
   assign pend = sync_q ^ deb_q;

   always_comb begin : rr_search
      found = 1'b0;
      grant = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && pend[(int'(rr_q) + k) % N]) begin
            found = 1'b1;
            grant = CH_BITS'((int'(rr_q) + k) % N);
         end
      end
   end

   always_comb begin : next_state
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      ch_d    = ch_q;
      rr_d    = rr_q;
      timer_d = timer_q;
      deb_d   = deb_q;
      press_d = '0;
      rel_d   = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = COUNT;
               ch_d    = grant;
               timer_d = TIMER_BITS'(TICKS - 1);
            end
         end
         COUNT: begin
            // A bounce on the owner wins over expiry in the same cycle.
            if (!pend[ch_q]) begin
               state_d = IDLE;
               ch_d    = '0;
            end else if (timer_q == '0) begin
               state_d = COMMIT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         COMMIT: begin
            deb_d[ch_q] = ~deb_q[ch_q];
            if (deb_q[ch_q]) rel_d[ch_q]   = 1'b1;
            else             press_d[ch_q] = 1'b1;
            rr_d    = (ch_q == CH_BITS'(N - 1)) ? '0 : ch_q + 1'b1;
            state_d = IDLE;
            ch_d    = '0;
         end
         default: begin
            state_d = IDLE;
            ch_d    = '0;
         end
      endcase
   end

   // NOTE: the synchroniser flops are reset too, so a reset pulse fully restarts qualification.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         meta_q  <= '0;
         sync_q  <= '0;
         deb_q   <= '0;
         press_q <= '0;
         rel_q   <= '0;
         ch_q    <= '0;
         rr_q    <= '0;
         timer_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         meta_q  <= noisy;
         sync_q  <= meta_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
         timer_q <= timer_d;
      end
   end

   assign debounced     = deb_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign busy          = (state_q != IDLE);
   assign active_ch     = ch_q;

endmodule
